// File: rtl/set_assoc_cache.sv
`default_nettype none
// ----------------------------------------------------------------------------
// set_assoc_cache: N-way set-associative write-back/write-allocate cache.
// Optional macro CACHE_STATS_EN adds hit_count/miss_count outputs. Rev 1.0
// ----------------------------------------------------------------------------
module set_assoc_cache #(
  parameter int ADDR_W = 30,
  parameter int CPU_W  = 32,
  parameter int MEM_W  = 128,
  parameter int SETS   = 8,
  parameter int WAYS   = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   cpu_req_val,
  output logic                                   cpu_req_rdy,
  input  logic [ADDR_W-1:0]                      cpu_req_addr,
  input  logic [CPU_W-1:0]                       cpu_req_data,
  input  logic [CPU_W/8-1:0]                     cpu_req_write,
  output logic                                   cpu_resp_val,
  output logic [CPU_W-1:0]                       cpu_resp_data,
  output logic                                   mem_req_val,
  input  logic                                   mem_req_rdy,
  output logic [ADDR_W-$clog2(MEM_W/CPU_W)-1:0]  mem_req_addr,
  output logic                                   mem_req_rw,
  output logic                                   mem_req_data_valid,
  input  logic                                   mem_req_data_ready,
  output logic [MEM_W-1:0]                       mem_req_data_bits,
  output logic [MEM_W/8-1:0]                     mem_req_data_mask,
  input  logic                                   mem_resp_val,
  input  logic [MEM_W-1:0]                       mem_resp_data
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                            hit_count,
  output logic [31:0]                            miss_count
`endif
);

  localparam int WORDS = MEM_W / CPU_W;
  localparam int BYTES = CPU_W / 8;
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int LA_W  = ADDR_W - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, RF_REQ, RF_WAIT, RESP} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [CPU_W-1:0]          wdata_q, wdata_d;
  logic [BYTES-1:0]          wmask_q, wmask_d;
  logic [WAY_W-1:0]          victim_q, victim_d;
  logic                      cpu_req_rdy_q, cpu_req_rdy_d;
  logic                      cpu_resp_val_q, cpu_resp_val_d;
  logic [CPU_W-1:0]          cpu_resp_data_q, cpu_resp_data_d;
  logic                      mem_req_val_q, mem_req_val_d;
  logic                      mem_req_rw_q, mem_req_rw_d;
  logic [LA_W-1:0]           mem_req_addr_q, mem_req_addr_d;
  logic                      mem_req_data_valid_q, mem_req_data_valid_d;
  logic [MEM_W-1:0]          mem_req_data_bits_q, mem_req_data_bits_d;
  logic [MEM_W/8-1:0]        mem_req_data_mask_q, mem_req_data_mask_d;
  logic [SETS-1:0][WAYS-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [SETS-1:0][WAY_W-1:0] rr_q, rr_d;

  logic [TAG_W-1:0]          tag_q  [SETS][WAYS];
  logic [MEM_W-1:0]          line_q [SETS][WAYS];

  logic                      line_we;
  logic [WAY_W-1:0]          line_way;
  logic [MEM_W-1:0]          line_wdata;

  // In IDLE the arrays are probed with the incoming address so a read hit can
  // be registered at accept time; afterwards the latched address is used.
  logic [ADDR_W-1:0]         lk_addr;
  logic [TAG_W-1:0]          lk_tag;
  logic [IDX_W-1:0]          lk_idx;
  logic [OFF_W-1:0]          lk_off;

  assign lk_addr = (state_q == IDLE) ? cpu_req_addr : addr_q;
  assign lk_tag  = lk_addr[ADDR_W-1 -: TAG_W];
  assign lk_idx  = lk_addr[OFF_W +: IDX_W];
  assign lk_off  = lk_addr[OFF_W-1:0];

  logic             hit, any_free;
  logic [WAY_W-1:0] hit_way, free_way, miss_way;

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    any_free = 1'b0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[lk_idx][w]) begin
        any_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  assign miss_way = any_free ? free_way : rr_q[lk_idx];

  function automatic logic [CPU_W-1:0] get_word(input logic [MEM_W-1:0] line,
                                                input logic [OFF_W-1:0] off);
    return line[int'(off)*CPU_W +: CPU_W];
  endfunction

  function automatic logic [MEM_W-1:0] merge_word(input logic [MEM_W-1:0] line,
                                                  input logic [OFF_W-1:0] off,
                                                  input logic [CPU_W-1:0] data,
                                                  input logic [BYTES-1:0] mask);
    logic [MEM_W-1:0] res;
    res = line;
    for (int b = 0; b < BYTES; b++) begin
      if (mask[b]) res[int'(off)*CPU_W + b*8 +: 8] = data[b*8 +: 8];
    end
    return res;
  endfunction

  assign mem_req_data_mask_d = '1;

  always_comb begin
    state_d              = state_q;
    addr_d               = addr_q;
    wdata_d              = wdata_q;
    wmask_d              = wmask_q;
    victim_d             = victim_q;
    cpu_req_rdy_d        = cpu_req_rdy_q;
    cpu_resp_val_d       = 1'b0;
    cpu_resp_data_d      = cpu_resp_data_q;
    mem_req_val_d        = mem_req_val_q;
    mem_req_rw_d         = mem_req_rw_q;
    mem_req_addr_d       = mem_req_addr_q;
    mem_req_data_valid_d = mem_req_data_valid_q;
    mem_req_data_bits_d  = mem_req_data_bits_q;
    valid_d              = valid_q;
    dirty_d              = dirty_q;
    rr_d                 = rr_q;
    line_we              = 1'b0;
    line_way             = hit_way;
    line_wdata           = merge_word(line_q[lk_idx][hit_way], lk_off, wdata_q, wmask_q);

    case (state_q)
      IDLE: begin
        cpu_req_rdy_d = 1'b1;
        if (cpu_req_val && cpu_req_rdy_q) begin
          state_d       = LOOKUP;
          cpu_req_rdy_d = 1'b0;
          addr_d        = cpu_req_addr;
          wdata_d       = cpu_req_data;
          wmask_d       = cpu_req_write;
          if (hit && (cpu_req_write == '0)) begin
            cpu_resp_val_d  = 1'b1;
            cpu_resp_data_d = get_word(line_q[lk_idx][hit_way], lk_off);
          end
        end
      end
      LOOKUP: begin
        if (hit) begin
          if (wmask_q != '0) begin
            line_we                  = 1'b1;
            dirty_d[lk_idx][hit_way] = 1'b1;
          end
          state_d       = IDLE;
          cpu_req_rdy_d = 1'b1;
        end else begin
          victim_d      = miss_way;
          mem_req_val_d = 1'b1;
          if (valid_q[lk_idx][miss_way] && dirty_q[lk_idx][miss_way]) begin
            state_d              = WB;
            mem_req_rw_d         = 1'b1;
            mem_req_addr_d       = {tag_q[lk_idx][miss_way], lk_idx};
            mem_req_data_valid_d = 1'b1;
            mem_req_data_bits_d  = line_q[lk_idx][miss_way];
          end else begin
            state_d        = RF_REQ;
            mem_req_rw_d   = 1'b0;
            mem_req_addr_d = {lk_tag, lk_idx};
          end
        end
      end
      WB: begin
        // Command and data channels retire independently.
        if (mem_req_rdy)        mem_req_val_d        = 1'b0;
        if (mem_req_data_ready) mem_req_data_valid_d = 1'b0;
        if (!mem_req_val_d && !mem_req_data_valid_d) begin
          state_d        = RF_REQ;
          mem_req_val_d  = 1'b1;
          mem_req_rw_d   = 1'b0;
          mem_req_addr_d = {lk_tag, lk_idx};
        end
      end
      RF_REQ: begin
        if (mem_req_rdy) begin
          mem_req_val_d = 1'b0;
          state_d       = RF_WAIT;
        end
      end
      RF_WAIT: begin
        if (mem_resp_val) begin
          line_we    = 1'b1;
          line_way   = victim_q;
          line_wdata = (wmask_q != '0) ? merge_word(mem_resp_data, lk_off, wdata_q, wmask_q)
                                       : mem_resp_data;
          if (valid_q[lk_idx][victim_q]) begin
            rr_d[lk_idx] = (rr_q[lk_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[lk_idx] + 1'b1;
          end
          valid_d[lk_idx][victim_q] = 1'b1;
          dirty_d[lk_idx][victim_q] = (wmask_q != '0);
          if (wmask_q == '0) begin
            cpu_resp_val_d  = 1'b1;
            cpu_resp_data_d = get_word(mem_resp_data, lk_off);
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d       = IDLE;
        cpu_req_rdy_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q              <= IDLE;
      addr_q               <= '0;
      wdata_q              <= '0;
      wmask_q              <= '0;
      victim_q             <= '0;
      cpu_req_rdy_q        <= 1'b0;
      cpu_resp_val_q       <= 1'b0;
      cpu_resp_data_q      <= '0;
      mem_req_val_q        <= 1'b0;
      mem_req_rw_q         <= 1'b0;
      mem_req_addr_q       <= '0;
      mem_req_data_valid_q <= 1'b0;
      mem_req_data_bits_q  <= '0;
      mem_req_data_mask_q  <= '0;
      valid_q              <= '0;
      dirty_q              <= '0;
      rr_q                 <= '0;
    end else begin
      state_q              <= state_d;
      addr_q               <= addr_d;
      wdata_q              <= wdata_d;
      wmask_q              <= wmask_d;
      victim_q             <= victim_d;
      cpu_req_rdy_q        <= cpu_req_rdy_d;
      cpu_resp_val_q       <= cpu_resp_val_d;
      cpu_resp_data_q      <= cpu_resp_data_d;
      mem_req_val_q        <= mem_req_val_d;
      mem_req_rw_q         <= mem_req_rw_d;
      mem_req_addr_q       <= mem_req_addr_d;
      mem_req_data_valid_q <= mem_req_data_valid_d;
      mem_req_data_bits_q  <= mem_req_data_bits_d;
      mem_req_data_mask_q  <= mem_req_data_mask_d;
      valid_q              <= valid_d;
      dirty_q              <= dirty_d;
      rr_q                 <= rr_d;
    end
  end

  // Payload storage needs no reset; validity lives in valid_q.
  always_ff @(posedge clk) begin
    if (line_we) begin
      line_q[lk_idx][line_way] <= line_wdata;
      tag_q[lk_idx][line_way]  <= lk_tag;
    end
  end

  assign cpu_req_rdy        = cpu_req_rdy_q;
  assign cpu_resp_val       = cpu_resp_val_q;
  assign cpu_resp_data      = cpu_resp_data_q;
  assign mem_req_val        = mem_req_val_q;
  assign mem_req_rw         = mem_req_rw_q;
  assign mem_req_addr       = mem_req_addr_q;
  assign mem_req_data_valid = mem_req_data_valid_q;
  assign mem_req_data_bits  = mem_req_data_bits_q;
  assign mem_req_data_mask  = mem_req_data_mask_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == LOOKUP) begin
      if (hit) hit_count_d  = hit_count_q + 32'd1;
      else     miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_set_assoc_cache.sv
`default_nettype none
// tb_set_assoc_cache: scoreboard bench; a flat reference word memory predicts every read.
module tb_set_assoc_cache;
  localparam int ADDR_W = 30;
  localparam int CPU_W  = 32;
  localparam int MEM_W  = 128;
  localparam int LA_W   = 28;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               cpu_req_val = 1'b0;
  logic               cpu_req_rdy;
  logic [ADDR_W-1:0]  cpu_req_addr = '0;
  logic [CPU_W-1:0]   cpu_req_data = '0;
  logic [3:0]         cpu_req_write = '0;
  logic               cpu_resp_val;
  logic [CPU_W-1:0]   cpu_resp_data;
  logic               mem_req_val;
  logic               mem_req_rdy = 1'b1;
  logic [LA_W-1:0]    mem_req_addr;
  logic               mem_req_rw;
  logic               mem_req_data_valid;
  logic               mem_req_data_ready = 1'b1;
  logic [MEM_W-1:0]   mem_req_data_bits;
  logic [MEM_W/8-1:0] mem_req_data_mask;
  logic               mem_resp_val = 1'b0;
  logic [MEM_W-1:0]   mem_resp_data = '0;
`ifdef CACHE_STATS_EN
  logic [31:0]        hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  set_assoc_cache dut (
    .clk(clk), .reset(reset),
    .cpu_req_val(cpu_req_val), .cpu_req_rdy(cpu_req_rdy), .cpu_req_addr(cpu_req_addr),
    .cpu_req_data(cpu_req_data), .cpu_req_write(cpu_req_write),
    .cpu_resp_val(cpu_resp_val), .cpu_resp_data(cpu_resp_data),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
    .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
    .mem_req_data_mask(mem_req_data_mask), .mem_resp_val(mem_resp_val),
    .mem_resp_data(mem_resp_data)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int errors = 0;
  int checks = 0;
  logic [CPU_W-1:0] sb [$];
  logic [MEM_W-1:0] mem_model [logic [LA_W-1:0]];
  logic [CPU_W-1:0] ref_mem [logic [ADDR_W-1:0]];

  // Per-operation observations of the memory side.
  int               rd_cnt, wr_cnt, resp_lat, wb_cmd_cyc, wb_dat_cyc, stall_n;
  logic             order_ok, got_data, op_done;
  logic [LA_W-1:0]  rd_addr, wr_addr;
  logic [MEM_W-1:0] wr_data;
  logic [MEM_W/8-1:0] wb_mask;

  task automatic check(input string tag, input logic [MEM_W-1:0] got, input logic [MEM_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MEM_W-1:0] init_line(input logic [LA_W-1:0] la);
    logic [MEM_W-1:0] l;
    if (la == 28'h10) return 128'h44444444_33333333_22222222_11223344;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = {4'hC, la[19:0], 8'(i)};
    return l;
  endfunction

  function automatic logic [MEM_W-1:0] mem_line(input logic [LA_W-1:0] la);
    return mem_model.exists(la) ? mem_model[la] : init_line(la);
  endfunction

  function automatic logic [CPU_W-1:0] ref_word(input logic [ADDR_W-1:0] a);
    logic [MEM_W-1:0] l;
    if (ref_mem.exists(a)) return ref_mem[a];
    l = init_line(a[29:2]);
    return l[int'(a[1:0])*32 +: 32];
  endfunction

  task automatic ref_write(input logic [ADDR_W-1:0] a, input logic [CPU_W-1:0] d, input logic [3:0] m);
    logic [CPU_W-1:0] w;
    w = ref_word(a);
    for (int b = 0; b < 4; b++) if (m[b]) w[b*8 +: 8] = d[b*8 +: 8];
    ref_mem[a] = w;
  endtask

  task automatic run_op(input logic [ADDR_W-1:0] a, input logic [CPU_W-1:0] d, input logic [3:0] m);
    int n;
    int cd;
    logic [LA_W-1:0] rf_la;
    rd_cnt = 0; wr_cnt = 0; resp_lat = 0; wb_cmd_cyc = 0; wb_dat_cyc = 0;
    order_ok = 1'b1; got_data = 1'b0; op_done = 1'b0; cd = 0; rf_la = '0;
    n = 0;
    @(negedge clk);
    while (!cpu_req_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_req_rdy) begin
      check("rdy_timeout", 0, 1);
      return;
    end
    cpu_req_val = 1'b1; cpu_req_addr = a; cpu_req_data = d; cpu_req_write = m;
    if (m == 4'b0) sb.push_back(ref_word(a));
    else ref_write(a, d, m);
    @(negedge clk);
    cpu_req_val = 1'b0; cpu_req_write = '0;
    for (int cyc = 1; cyc < 100; cyc++) begin
      mem_resp_val = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mem_resp_val  = 1'b1;
          mem_resp_data = mem_line(rf_la);
        end
      end
      if (cpu_resp_val) begin
        if (resp_lat == 0) resp_lat = cyc;
        if (sb.size() == 0) check("spurious_resp", 1, 0);
        else check("resp_data", cpu_resp_data, sb.pop_front());
      end
      if (cpu_req_rdy) begin
        op_done = 1'b1;
        break;
      end
      mem_req_data_ready = 1'b1;
      if (mem_req_data_valid) begin
        wb_dat_cyc++;
        wb_mask = mem_req_data_mask;
        if (stall_n > 0) begin
          mem_req_data_ready = 1'b0;
          stall_n--;
        end else begin
          wr_data  = mem_req_data_bits;
          got_data = 1'b1;
        end
      end
      if (mem_req_val) begin
        if (mem_req_rw) begin
          wb_cmd_cyc++;
          wr_cnt++;
          wr_addr = mem_req_addr;
        end else begin
          rd_cnt++;
          rd_addr = mem_req_addr;
          rf_la   = mem_req_addr;
          cd      = 2;
          if (wr_cnt > 0 && !got_data) order_ok = 1'b0;
        end
      end
      @(negedge clk);
    end
    mem_resp_val = 1'b0;
    if (!op_done) check("op_timeout", 0, 1);
    if (wr_cnt > 0 && got_data) mem_model[wr_addr] = wr_data;
  endtask

  initial begin
    int n;
    logic seen;
    stall_n = 0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {cpu_req_rdy, cpu_resp_val, mem_req_val, mem_req_rw, mem_req_data_valid,
                          |mem_req_data_mask, |cpu_resp_data, |mem_req_addr}, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", cpu_req_rdy, 1);

    // Cold miss then hit in the same line.
    run_op(30'h40, 0, 4'b0);
    check("s1_rd_cnt", rd_cnt, 1);
    check("s1_rd_addr", rd_addr, 28'h10);
    check("s1_wr_cnt", wr_cnt, 0);
    run_op(30'h41, 0, 4'b0);
    check("s1_hit_rd_cnt", rd_cnt, 0);
    check("s1_hit_latency", resp_lat, 1);
`ifdef CACHE_STATS_EN
    check("stats_hit", hit_count, 1);
    check("stats_miss", miss_count, 1);
`endif

    // Partial write hit, then read back merged word.
    run_op(30'h40, 32'hAABBCCDD, 4'b0011);
    check("wr_hit_no_resp", resp_lat, 0);
    check("wr_hit_rd_cnt", rd_cnt, 0);
    run_op(30'h40, 0, 4'b0);
    check("merge_hit_rd_cnt", rd_cnt, 0);

    // Fill second way, then evict the dirty first way.
    run_op(30'h60, 0, 4'b0);
    check("w1_rd_addr", rd_addr, 28'h18);
    check("w1_wr_cnt", wr_cnt, 0);
    run_op(30'h80, 0, 4'b0);
    check("evict_wr_cnt", wr_cnt, 1);
    check("evict_wr_addr", wr_addr, 28'h10);
    check("evict_wr_data", wr_data, 128'h44444444_33333333_22222222_1122CCDD);
    check("evict_rd_addr", rd_addr, 28'h20);

    // Dirty way1, then evict it with the data channel stalled.
    run_op(30'h61, 32'h55667788, 4'b1111);
    check("w61_rd_cnt", rd_cnt, 0);
    stall_n = 3;
    run_op(30'hA0, 0, 4'b0);
    check("stall_cmd_cycles", wb_cmd_cyc, 1);
    check("stall_data_cycles", wb_dat_cyc, 4);
    check("stall_order", order_ok, 1);
    check("stall_wr_addr", wr_addr, 28'h18);
    check("stall_wr_word1", wr_data[63:32], 32'h55667788);
    check("stall_mask", wb_mask, {(MEM_W/8){1'b1}});
    check("stall_rd_addr", rd_addr, 28'h28);

    // Evicted line comes back from memory; clean victim needs no write-back.
    run_op(30'h61, 0, 4'b0);
    check("reload_rd_cnt", rd_cnt, 1);
    check("reload_wr_cnt", wr_cnt, 0);

    // Reset while waiting for refill data.
    @(negedge clk);
    cpu_req_val = 1'b1; cpu_req_addr = 30'h40; cpu_req_write = '0;
    @(negedge clk);
    cpu_req_val = 1'b0;
    n = 0;
    while (!(mem_req_val && !mem_req_rw) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("abort_rfreq_seen", mem_req_val, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_outputs", {cpu_req_rdy, cpu_resp_val, mem_req_val, mem_req_rw, mem_req_data_valid,
                            |mem_req_data_mask, |cpu_resp_data, |mem_req_addr, |mem_req_data_bits}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_resp_val = 1'b1; mem_resp_data = '1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_resp_val = 1'b0;
      seen = seen | cpu_resp_val;
    end
    check("abort_late_resp_ignored", seen, 0);
    run_op(30'h40, 0, 4'b0);
    check("abort_reread_miss", rd_cnt, 1);
    check("abort_reread_addr", rd_addr, 28'h10);

    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
